uart_rx_decoder: RTL

//  Receives the 8N1 serial stream driven on io_uartStd_txd by the SoC top and turns it

---
 rtl/uart_rx_decoder.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_decoder.sv
// uart_rx_decoder
//   8N1 UART receiver feeding a small FIFO that is read through a valid/ready
//   stream. Framing errors and FIFO overflows are reported as 1-cycle pulses.
//
// Ports
//   io_clock         in   system clock, rising edge
//   io_reset         in   asynchronous active-low reset
//   io_rxd           in   serial line, idle high, asynchronous to io_clock
//   io_data_valid    out  FIFO head holds a byte
//   io_data_ready    in   consumer takes the head when valid & ready
//   io_data_payload  out  FIFO head byte, bit 0 = first data bit on the line
//   io_frameError    out  pulse: stop bit sampled low, byte discarded
//   io_overflow      out  pulse: good byte dropped, FIFO full
//   io_busy          out  receiver FSM is not idle
//   io_level         out  FIFO occupancy, 0..FIFO_DEPTH
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | line idle, waiting for a 1->0 transition
// S_START | waiting half a bit, then confirming the start bit is still low
// S_DATA  | sampling 8 data bits at bit centres, LSB first
// S_STOP  | sampling the stop bit; high pushes the byte, low is a framing error
// S_BREAK | line held low after a framing error, waiting for it to go high
module uart_rx_decoder #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             io_clock,
  input  logic             io_reset,
  input  logic             io_rxd,
  output logic             io_data_valid,
  input  logic             io_data_ready,
  output logic [7:0]       io_data_payload,
  output logic             io_frameError,
  output logic             io_overflow,
  output logic             io_busy,
  output logic [LVL_W-1:0] io_level
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LOAD_BIT  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LOAD_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  // line synchronizer; rxd_prev_q gives the previous synchronized sample
  logic rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic start_edge;

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= io_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign start_edge = rxd_prev_q & ~rxd_sync_q;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             push_q, push_d;
  logic             frame_err_q, frame_err_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          cnt_d   = LOAD_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rxd_sync_q) begin
          cnt_d     = LOAD_BIT;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          // start bit vanished before its centre: treat as a glitch
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          cnt_d     = LOAD_BIT;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d = '0;
          if (rxd_sync_q) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxd_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // receive FIFO; payload_q mirrors the head entry so the output is a flop
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [7:0]       payload_q, payload_d;
  logic             ovf_q, ovf_d;
  logic             pop, push_ok;

  always_comb begin
    pop      = (count_q != '0) & io_data_ready;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    push_ok  = push_q & ((count_q != LVL_FULL) | pop);
    ovf_d    = push_q & ~push_ok;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + LVL_W'(1);
    else if (!push_ok && pop) count_d = count_q - LVL_W'(1);
    payload_d = (count_d != '0) ? mem_d[rd_ptr_d] : payload_q;
  end

  always_ff @(posedge io_clock or negedge io_reset) begin
    if (!io_reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      payload_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      payload_q <= payload_d;
      ovf_q     <= ovf_d;
    end
  end

  assign io_data_valid   = (count_q != '0);
  assign io_data_payload = payload_q;
  assign io_level        = count_q;
  assign io_frameError   = frame_err_q;
  assign io_overflow     = ovf_q;
  assign io_busy         = (state_q != S_IDLE);

endmodule
